// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: per-tile sequencer for the MxN systolic MAC array.
// Sequence: clear accumulators, skewed operand feed, wavefront drain, then
// stream the M*N results row-major over a valid/ready port.
// Optional macro SYSTOLIC_CTRL_PERF_EN adds tile cycle / stall counters;
// without it the perf ports are tied to zero.
module systolic_tile_ctrl #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int K_MAX = 16,
  parameter int KW    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      acc_clr,
  output logic [KW+2:0]             feed_t,
  output logic [M-1:0]              row_en,
  output logic [N-1:0]              col_en,
  output logic [$clog2(M*N)-1:0]    res_sel,
  input  logic [ACC_W-1:0]          res_in,
  output logic [ACC_W-1:0]          res_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_stalls
);

  localparam int FTW       = KW + 3;
  localparam int SELW      = $clog2(M*N);
  localparam int MAXMN     = (M > N) ? M : N;
  localparam int DRAIN_LEN = M + N - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  localparam logic [KW-1:0]   KMAX_L     = KW'(K_MAX);
  localparam logic [SELW-1:0] SEL_LAST   = SELW'(M*N - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [FTW-1:0]    feed_t_q, feed_t_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              err_q, err_d;
  logic [FTW-1:0]    feed_last;

  // Last feed index: k_len + max(M,N) - 2, so FEED spans k_len+max(M,N)-1 cycles.
  assign feed_last = FTW'(k_q) + FTW'(MAXMN - 1) - FTW'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      feed_t_q <= '0;
      drain_q  <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      feed_t_q <= feed_t_d;
      drain_q  <= drain_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; counters clear whenever their state is not active.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    feed_t_d = '0;
    drain_d  = '0;
    sel_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((k_len != '0) && (k_len <= KMAX_L)) begin
            k_d     = k_len;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_FEED;
      S_FEED: begin
        if (feed_t_q == feed_last) state_d = S_DRAIN;
        else                       feed_t_d = feed_t_q + FTW'(1);
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_READ;
        else                       drain_d = drain_q + DW'(1);
      end
      S_READ: begin
        sel_d = sel_q;
        if (res_ready) begin
          if (sel_q == SEL_LAST) begin
            state_d = S_DONE;
            sel_d   = '0;
          end else begin
            sel_d = sel_q + SELW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition from a busy state.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      feed_t_d = '0;
      drain_d  = '0;
      sel_d    = '0;
    end
  end

  // Output decode from registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    acc_clr   = (state_q == S_CLEAR);
    res_valid = (state_q == S_READ);
    err       = err_q;
    feed_t    = feed_t_q;
    res_sel   = sel_q;
    res_data  = res_valid ? res_in : '0;
    row_en    = '0;
    col_en    = '0;
    for (int unsigned i = 0; i < M; i++) begin
      row_en[i] = (state_q == S_FEED) && (feed_t_q >= FTW'(i)) &&
                  (feed_t_q < FTW'(i) + FTW'(k_q));
    end
    for (int unsigned j = 0; j < N; j++) begin
      col_en[j] = (state_q == S_FEED) && (feed_t_q >= FTW'(j)) &&
                  (feed_t_q < FTW'(j) + FTW'(k_q));
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] cyc_run_q, stall_run_q, perf_cycles_q, perf_stalls_q;

  // Running tile counters, published in DONE (aborted tiles never publish).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_run_q     <= '0;
      stall_run_q   <= '0;
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        cyc_run_q   <= '0;
        stall_run_q <= '0;
      end else begin
        cyc_run_q <= cyc_run_q + 32'd1;
        if ((state_q == S_READ) && !res_ready) stall_run_q <= stall_run_q + 32'd1;
      end
      if ((state_q == S_DONE) && !abort) begin
        perf_cycles_q <= cyc_run_q + 32'd1;
        perf_stalls_q <= stall_run_q;
      end
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl: a tile-level model predicts
// cycle-stamped output events; a negedge monitor pops and compares them.
module tb_systolic_tile_ctrl;

  localparam int M = 4, N = 4, ACC_W = 32, K_MAX = 16, KW = 5;
  localparam int NRES = M * N;
  localparam int MAXMN = 4;
  localparam int NCYC = 16384;
  localparam int NOCUT = 1 << 30;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic busy, done, err, acc_clr, res_valid;
  logic [KW+2:0] feed_t;
  logic [M-1:0] row_en;
  logic [N-1:0] col_en;
  logic [3:0] res_sel;
  logic [ACC_W-1:0] res_in, res_data;
  logic [31:0] perf_cycles, perf_stalls;
  logic [31:0] salt = 32'h0;

  function automatic logic [31:0] data_of(input int idx, input logic [31:0] s);
    return s ^ (32'(idx) * 32'h0100_0193);
  endfunction

  assign res_in = data_of(int'(res_sel), salt);

  systolic_tile_ctrl #(.M(M), .N(N), .ACC_W(ACC_W), .K_MAX(K_MAX), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .err(err), .acc_clr(acc_clr), .feed_t(feed_t),
    .row_en(row_en), .col_en(col_en), .res_sel(res_sel), .res_in(res_in),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [47:0] vec;   // {clr,done,err,valid,row,col,sel,data}
    int          ft;    // expected feed_t, -1 when not checked
  } ev_t;

  ev_t q[$];
  bit rdy_pat [0:NCYC-1];
  bit busy_exp[0:NCYC-1];
  int tests = 0, fails = 0;
  logic [31:0] exp_pc = 0, exp_ps = 0;

  function automatic logic [47:0] pack(input logic clr, input logic dn, input logic er,
                                       input logic vl, input logic [3:0] row,
                                       input logic [3:0] col, input logic [3:0] sel,
                                       input logic [31:0] d);
    return {clr, dn, er, vl, row, col, sel, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void push_ev(input int c, input logic [47:0] v, input int ft, input int cut);
    ev_t e;
    if (c < cut) begin
      e.cyc = c; e.vec = v; e.ft = ft;
      q.push_back(e);
    end
  endfunction

  // Tile model: start sampled at edge E; events at or after 'cut' are suppressed.
  task automatic plan_tile(input int E, input int k, input int mode, input int cut,
                           output int t_end);
    int F, t, rs, idx, stalls;
    logic [3:0] row;
    bit r;
    F = k + MAXMN - 1;
    push_ev(E, pack(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 32'h0), -1, cut);
    for (int f = 0; f < F; f++) begin
      row = '0;
      for (int i = 0; i < M; i++) row[i] = (f >= i) && (f < i + k);
      push_ev(E + 1 + f, pack(0, 0, 0, 0, row, row, 4'h0, 32'h0), f, cut);
    end
    rs = E + 1 + F + (M + N - 1);
    t = rs; idx = 0; stalls = 0;
    while (idx < NRES) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ((t - rs) % 2) == 0;
        default: r = ($urandom_range(0, 2) != 0);
      endcase
      rdy_pat[t] = r;
      push_ev(t, pack(0, 0, 0, 1, 4'h0, 4'h0, 4'(idx), data_of(idx, salt)), -1, cut);
      if (r) idx++; else stalls++;
      t++;
    end
    push_ev(t, pack(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 32'h0), -1, cut);
    for (int c = E; c <= t; c++) if (c < cut) busy_exp[c] = 1'b1;
    t_end = t;
`ifdef SYSTOLIC_CTRL_PERF_EN
    if (t < cut) begin
      exp_pc = 32'(t - E + 1);
      exp_ps = 32'(stalls);
    end
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Issue a start request; cut_off is relative to the sampling edge, -1 for none.
  task automatic issue(input int k, input int mode, input int cut_off,
                       output int E, output int t_end);
    int cut;
    E = cyc + 1;
    cut = (cut_off < 0) ? NOCUT : E + cut_off;
    salt = $urandom;
    start = 1'b1;
    k_len = KW'(k);
    if (k >= 1 && k <= K_MAX) plan_tile(E, k, mode, cut, t_end);
    else begin
      push_ev(E, pack(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 32'h0), -1, NOCUT);
      t_end = E;
    end
    step();
    start = 1'b0;
    k_len = KW'($urandom_range(0, 31));
  endtask

  task automatic check_perf();
    chk("perf_cycles", 64'(perf_cycles), 64'(exp_pc));
    chk("perf_stalls", 64'(perf_stalls), 64'(exp_ps));
  endtask

  task automatic check_all_zero();
    chk("rst_ctrl", 64'({busy, done, err, acc_clr, res_valid}), 64'h0);
    chk("rst_feed", 64'({feed_t, row_en, col_en}), 64'h0);
    chk("rst_res", 64'({res_sel, res_data}), 64'h0);
  endtask

  // Ready driver follows the pattern the model planned.
  initial forever begin
    @(posedge clk);
    #1;
    res_ready = rdy_pat[cyc];
  end

  // Monitor: compares every presented output event against the scoreboard.
  initial forever begin
    ev_t e;
    logic present;
    @(negedge clk);
    chk("busy", 64'(busy), 64'(busy_exp[cyc]));
    present = acc_clr | done | err | res_valid | (|row_en) | (|col_en);
    if (present) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event @cyc %0d: got %0h expected none", cyc,
                 pack(acc_clr, done, err, res_valid, row_en, col_en,
                      res_valid ? res_sel : 4'h0, res_valid ? res_data : 32'h0));
      end else begin
        e = q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        chk("event", 64'(pack(acc_clr, done, err, res_valid, row_en, col_en,
                              res_valid ? res_sel : 4'h0, res_valid ? res_data : 32'h0)),
            64'(e.vec));
        if (e.ft >= 0) chk("feed_t", 64'(feed_t), 64'(e.ft));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      tests++; fails++;
      $display("FAIL missing_event @cyc %0d: got none expected %0h at %0d", cyc, e.vec, e.cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int E, te, co, k, md;
    for (int i = 0; i < NCYC; i++) begin
      rdy_pat[i] = 1'b1;
      busy_exp[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) step();
    check_all_zero();
    check_perf();
    rst_n = 1'b1;
    repeat (2) step();

    // Basic tile and alternating-ready tile.
    issue(5, 0, -1, E, te); wait_until(te + 1); check_perf();
    issue(5, 1, -1, E, te); wait_until(te + 1); check_perf();

    // Rejected starts.
    issue(0, 0, -1, E, te); step();
    issue(17, 0, -1, E, te); repeat (2) step();

    // Start during FEED is ignored.
    issue(8, 0, -1, E, te);
    wait_until(E + 3);
    start = 1'b1; k_len = 5'd3;
    step();
    start = 1'b0;
    wait_until(te + 1); check_perf();

    // Abort in DRAIN (k=5: DRAIN spans E+9..E+15), then a k=1 tile.
    issue(5, 0, 11, E, te);
    wait_until(E + 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 64'({busy, done}), 64'h0);
    check_perf();
    issue(1, 2, -1, E, te); wait_until(te + 1); check_perf();

    // Reset in READ at res_sel=7 (k=16: READ starts at E+27).
    issue(16, 0, 34, E, te);
    wait_until(E + 34);
    chk("sel_before_rst", 64'({res_valid, res_sel}), 64'h17);
    #1 rst_n = 1'b0;
    #1 check_all_zero();
`ifdef SYSTOLIC_CTRL_PERF_EN
    exp_pc = 0; exp_ps = 0;
`endif
    check_perf();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(16, 0, -1, E, te); wait_until(te + 1); check_perf();

    // Randomized tiles with occasional aborts and rejected starts.
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 20);
      md = $urandom_range(0, 2);
      if (k >= 1 && k <= K_MAX && $urandom_range(0, 3) == 0) begin
        co = $urandom_range(1, k + 3 + 7 + 1);
        issue(k, md, co, E, te);
        wait_until(E + co - 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_perf();
      end else begin
        issue(k, md, -1, E, te);
        wait_until(te + 1);
        check_perf();
      end
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    chk("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
